// File: rtl/rpn_stack_eval.sv
// RPN evaluator: sole initiator on the stack_ctrl push/pop port; pushes operands, folds operators, pops the result on evaluate.
// Build option: define RPN_MUL_EN to make opcode 2 a multiply; otherwise opcode 2 is an illegal opcode.
module rpn_stack_eval #(
    parameter int IO_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tok_valid,
    output logic                tok_ready,
    input  logic [1:0]          tok_kind,
    input  logic [IO_WIDTH-1:0] tok_data,
    output logic [IO_WIDTH-1:0] result,
    output logic                result_valid,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [IO_WIDTH-1:0] stack_din,
    output logic                stack_push,
    output logic                stack_pop,
    input  logic [IO_WIDTH-1:0] stack_dout,
    input  logic                stack_poped,
    input  logic                stack_full,
    input  logic                stack_empty
);
    typedef enum logic [3:0] {DRAIN, IDLE, PUSH, SETTLE, POP, POPW1, POPW2, EXEC, ERR} state_t;
    typedef enum logic [1:0] {M_DRAIN, M_OPER, M_EVAL} mode_t;

    localparam logic [1:0] K_OPND    = 2'd0;
    localparam logic [1:0] K_OPER    = 2'd1;
    localparam logic [1:0] K_EVAL    = 2'd2;
    localparam logic [1:0] E_UNDER   = 2'd1;
    localparam logic [1:0] E_OVER    = 2'd2;
    localparam logic [1:0] E_ILLEGAL = 2'd3;

    state_t                state, state_nxt;
    mode_t                 mode;
    logic                  pop_a, ack_q, op_legal;
    logic [1:0]            opcode, cause;
    logic [IO_WIDTH-1:0]   opa, opb, alu;

`ifdef RPN_MUL_EN
    assign op_legal = 1'b1;
`else
    assign op_legal = (tok_data[1:0] != 2'd2);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= DRAIN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cause     = 2'd0;
        case (state)
            DRAIN:  state_nxt = stack_empty ? IDLE : POP;
            IDLE: if (tok_valid) begin
                case (tok_kind)
                    K_OPND: if (stack_full) begin state_nxt = ERR; cause = E_OVER; end
                            else state_nxt = PUSH;
                    K_OPER: if (!op_legal) begin state_nxt = ERR; cause = E_ILLEGAL; end
                            else if (stack_empty) begin state_nxt = ERR; cause = E_UNDER; end
                            else state_nxt = POP;
                    K_EVAL: if (stack_empty) begin state_nxt = ERR; cause = E_UNDER; end
                            else state_nxt = POP;
                    default: begin state_nxt = ERR; cause = E_ILLEGAL; end
                endcase
            end
            PUSH:   state_nxt = SETTLE;
            SETTLE: state_nxt = IDLE;
            POP:    state_nxt = POPW1;
            POPW1:  state_nxt = POPW2;
            POPW2: begin
                case (mode)
                    M_DRAIN: state_nxt = DRAIN;
                    M_EVAL:  state_nxt = IDLE;
                    default: begin
                        // b has just been popped; stack status is settled here for the a-pop check
                        if (pop_a)            state_nxt = EXEC;
                        else if (stack_empty) begin state_nxt = ERR; cause = E_UNDER; end
                        else                  state_nxt = POP;
                    end
                endcase
            end
            EXEC:    state_nxt = PUSH;
            ERR:     state_nxt = ERR;
            default: state_nxt = DRAIN;
        endcase
    end

    always_comb begin
        tok_ready  = (state == IDLE);
        stack_push = (state == PUSH);
        stack_pop  = (state == POP);
        err        = (state == ERR);
    end

    always_comb begin
        alu = '0;
        case (opcode)
            2'd0: alu = opa + opb;
            2'd1: alu = opa - opb;
`ifdef RPN_MUL_EN
            2'd2: alu = opa * opb;
`else
            2'd2: alu = '0;
`endif
            2'd3: alu = opa & opb;
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode         <= M_DRAIN;
            pop_a        <= 1'b0;
            ack_q        <= 1'b0;
            opcode       <= 2'd0;
            opa          <= '0;
            opb          <= '0;
            stack_din    <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            err_code     <= 2'd0;
        end else begin
            result_valid <= 1'b0;
            ack_q        <= stack_poped;
            if (state_nxt == ERR && state != ERR) err_code <= cause;
            case (state)
                IDLE: if (tok_valid) begin
                    opcode <= tok_data[1:0];
                    pop_a  <= 1'b0;
                    mode   <= (tok_kind == K_EVAL) ? M_EVAL : M_OPER;
                    if (tok_kind == K_OPND) stack_din <= tok_data;
                end
                POPW2: begin
                    if (mode == M_EVAL) begin
                        result_valid <= 1'b1;
                        if (ack_q) result <= stack_dout;
                    end else if (mode == M_OPER) begin
                        pop_a <= 1'b1;
                        if (ack_q) begin
                            if (pop_a) opa <= stack_dout;
                            else       opb <= stack_dout;
                        end
                    end
                end
                EXEC: stack_din <= alu;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rpn_stack_eval.sv
// Self-checking bench for rpn_stack_eval: behavioural 8-deep stack on the push/pop port and a queue-based RPN reference model.
module tb_rpn_stack_eval;
    localparam int W     = 8;
    localparam int DEPTH = 8;
`ifdef RPN_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tok_valid, tok_ready;
    logic [1:0]   tok_kind;
    logic [W-1:0] tok_data;
    logic [W-1:0] result;
    logic         result_valid, err;
    logic [1:0]   err_code;
    logic [W-1:0] stack_din;
    logic         stack_push, stack_pop;
    logic [W-1:0] stack_dout  = '0;
    logic         stack_poped = 1'b0;
    logic         stack_full, stack_empty;

    rpn_stack_eval #(.IO_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .tok_valid(tok_valid), .tok_ready(tok_ready),
        .tok_kind(tok_kind), .tok_data(tok_data), .result(result), .result_valid(result_valid),
        .err(err), .err_code(err_code), .stack_din(stack_din), .stack_push(stack_push),
        .stack_pop(stack_pop), .stack_dout(stack_dout), .stack_poped(stack_poped),
        .stack_full(stack_full), .stack_empty(stack_empty)
    );

    always #5 clk = ~clk;

    // Stack peripheral: no reset, so contents survive rst_n like the real stack_ctrl
    logic [W-1:0] stk_mem [DEPTH];
    int           stk_cnt = 0;
    always @(posedge clk) begin
        stack_poped <= stack_pop;
        if (stack_push && stk_cnt < DEPTH) begin
            stk_mem[stk_cnt] <= stack_din;
            stk_cnt          <= stk_cnt + 1;
        end else if (stack_pop && stk_cnt > 0) begin
            stack_dout <= stk_mem[stk_cnt-1];
            stk_cnt    <= stk_cnt - 1;
        end
    end
    assign stack_full  = (stk_cnt == DEPTH);
    assign stack_empty = (stk_cnt == 0);

    int           n_vec = 0, n_fail = 0;
    int           cyc = 0, last_pop = -100;
    int           n_push = 0, n_pop = 0, n_rv = 0;
    logic [W-1:0] exp_result = '0;
    logic [W-1:0] mq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (stack_push) n_push++;
        if (stack_pop) begin n_pop++; last_pop = cyc; end
        if (stack_push || stack_pop) check("push_pop_exclusive", 32'(stack_push & stack_pop), 0);
        if (result_valid) begin
            n_rv++;
            check("pop_to_valid", 32'(cyc - last_pop), 3);
            check("result", 32'(result), 32'(exp_result));
        end
    endtask

    // Reference RPN semantics on a bounded queue
    task automatic model(input logic [1:0] k, input logic [W-1:0] d,
                         output logic [1:0] code, output logic [W-1:0] res, output int lat);
        int a, b;
        code = 2'd0; res = '0; lat = 0;
        case (k)
            2'd0: if (mq.size() >= DEPTH) code = 2'd2;
                  else begin mq.push_back(d); lat = 3; end
            2'd1: if (d[1:0] == 2'd2 && !MUL_EN) code = 2'd3;
                  else if (mq.size() < 2) begin code = 2'd1; mq.delete(); end
                  else begin
                      b = int'(mq.pop_back());
                      a = int'(mq.pop_back());
                      case (d[1:0])
                          2'd0: res = 8'(a + b);
                          2'd1: res = 8'(a - b);
                          2'd2: res = 8'(a * b);
                          default: res = 8'(a & b);
                      endcase
                      mq.push_back(res);
                      lat = 10;
                  end
            2'd2: if (mq.size() == 0) code = 2'd1;
                  else begin res = mq.pop_back(); lat = 4; end
            default: code = 2'd3;
        endcase
    endtask

    task automatic send(input logic [1:0] k, input logic [W-1:0] d, output int lat);
        int g = 0;
        tok_valid = 1'b1; tok_kind = k; tok_data = d;
        while (!tok_ready && g < 100) begin step(); g++; end
        check("accept_timeout", 32'(g < 100), 1);
        step();
        tok_valid = 1'b0;
        lat = 1;
        while (!tok_ready && !err && lat < 100) begin step(); lat++; end
    endtask

    task automatic run_tok(input logic [1:0] k, input logic [W-1:0] d, output logic [1:0] code);
        logic [W-1:0] res;
        int exp_lat, lat, rv0;
        model(k, d, code, res, exp_lat);
        if (k == 2'd2 && code == 2'd0) exp_result = res;
        rv0 = n_rv;
        send(k, d, lat);
        if (code != 2'd0) begin
            check("err", 32'(err), 1);
            check("err_code", 32'(err_code), 32'(code));
            check("ready_in_err", 32'(tok_ready), 0);
        end else begin
            check("latency", 32'(lat), 32'(exp_lat));
            check("err_clear", 32'(err), 0);
            if (k == 2'd2) check("valid_pulses", 32'(n_rv - rv0), 1);
        end
    endtask

    task automatic do_reset(output int drain_pops);
        int g = 0;
        rst_n = 1'b0; tok_valid = 1'b0;
        step(); step();
        check("reset_values", 32'({tok_ready, result, result_valid, err, err_code,
                                   stack_push, stack_pop, stack_din}), 0);
        n_pop = 0;
        rst_n = 1'b1;
        while (!tok_ready && g < 200) begin step(); g++; end
        check("drain_done", 32'(tok_ready), 1);
        check("drain_empty", 32'(stk_cnt), 0);
        drain_pops = n_pop;
        mq.delete();
        n_push = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   code, k;
        logic [W-1:0] d;
        int           dp, p0, r;
        rst_n = 1'b0; tok_valid = 1'b0; tok_kind = 2'd0; tok_data = '0;

        do_reset(dp);
        run_tok(0, 8'd3, code); run_tok(0, 8'd4, code);
        run_tok(1, 8'd0, code); run_tok(2, 8'd0, code);
        check("add_result", 32'(result), 7);
        check("add_stack_empty", 32'(stk_cnt), 0);

        run_tok(0, 8'd3, code); run_tok(0, 8'd5, code);
        run_tok(1, 8'd1, code); run_tok(2, 8'd0, code);
        check("sub_wrap", 32'(result), 32'hFE);

        run_tok(0, 8'h10, code); run_tok(0, 8'h11, code);
        p0 = n_pop;
        run_tok(1, 8'd2, code);
        if (MUL_EN) begin
            run_tok(2, 8'd0, code);
            check("mul_result", 32'(result), 32'h10);
        end else begin
            check("mul_illegal_code", 32'(err_code), 3);
            check("mul_no_pops", 32'(n_pop - p0), 0);
        end

        do_reset(dp);
        for (int i = 0; i < DEPTH; i++) run_tok(0, 8'(i + 1), code);
        run_tok(0, 8'h99, code);
        check("overflow_code", 32'(err_code), 2);
        check("overflow_pushes", 32'(n_push), 8);

        do_reset(dp);
        run_tok(0, 8'd1, code);
        p0 = n_pop;
        run_tok(1, 8'd0, code);
        check("underflow_pops", 32'(n_pop - p0), 1);
        check("underflow_code", 32'(err_code), 1);
        for (int i = 0; i < 5; i++) step();
        check("err_ready_low", 32'(tok_ready), 0);
        check("err_sticky", 32'(err), 1);

        do_reset(dp);
        run_tok(2, 8'd0, code);
        check("eval_empty_code", 32'(err_code), 1);

        do_reset(dp);
        run_tok(0, 8'd2, code); run_tok(0, 8'd6, code); run_tok(0, 8'd9, code);
        do_reset(dp);
        check("drain_pops", 32'(dp), 3);
        run_tok(0, 8'd1, code); run_tok(0, 8'd1, code);
        run_tok(1, 8'd0, code); run_tok(2, 8'd0, code);
        check("post_drain_result", 32'(result), 2);

        do_reset(dp);
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            d = 8'($urandom);
            if (r < 55)      k = 2'd0;
            else if (r < 85) k = 2'd1;
            else if (r < 97) k = 2'd2;
            else             k = 2'd3;
            run_tok(k, d, code);
            if (code != 2'd0) do_reset(dp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
